// File: rtl/player_shot_controller.sv
// Player projectile controller: spawns, moves and retires up to four upward shots and flags boss collisions.
// Define PLAYER_SHOT_AUTOFIRE_EN to make holding fire spawn repeatedly; by default only a fire rising edge requests a shot.
module player_shot_controller #(
   parameter int unsigned SHOT_SPEED = 4,
   parameter int unsigned SHOT_W     = 4,
   parameter int unsigned SHOT_H     = 8,
   parameter int unsigned COOLDOWN   = 6
) (
   input  logic       clk_master_i,
   input  logic       rst_i,
   input  logic       pulse_cycleStep_i,
   input  logic       fire_i,
   input  logic [9:0] playerX_i,
   input  logic [8:0] playerY_i,
   input  logic [9:0] bossLocX_i,
   input  logic [8:0] bossLocY_i,
   input  logic [9:0] bossWidth_i,
   input  logic [8:0] bossHeight_i,
   output logic [9:0] shot1X_o,
   output logic [9:0] shot2X_o,
   output logic [9:0] shot3X_o,
   output logic [9:0] shot4X_o,
   output logic [8:0] shot1Y_o,
   output logic [8:0] shot2Y_o,
   output logic [8:0] shot3Y_o,
   output logic [8:0] shot4Y_o,
   output logic [3:0] shotActive_o,
   output logic       bossHit_o
);
   // state       | meaning
   // SLOT_IDLE   | slot free, coordinates hold their last value
   // SLOT_ACTIVE | projectile live, moves up once per tick
   typedef enum logic {SLOT_IDLE, SLOT_ACTIVE} slot_state_t;

   localparam int unsigned CD_W = $clog2(COOLDOWN + 1);
   localparam logic [8:0]  SPEED9  = 9'(SHOT_SPEED);
   localparam logic [8:0]  SHOT_H9 = 9'(SHOT_H);
   localparam logic [10:0] SHOT_W11 = 11'(SHOT_W);
   localparam logic [10:0] SHOT_H11 = 11'(SHOT_H);
   // Loaded one short so that consecutive spawns land exactly COOLDOWN ticks apart.
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN - 1);

   slot_state_t     slot_q [4];
   slot_state_t     slot_d [4];
   logic [9:0]      x_q [4];
   logic [9:0]      x_d [4];
   logic [8:0]      y_q [4];
   logic [8:0]      y_d [4];
   logic [CD_W-1:0] cooldown_q, cooldown_d;
   logic            pending_q, pending_d;
   logic            prev_fire_q;
   logic            hit_q, hit_d;
   logic            req;
   logic            placed;
   logic [8:0]      y_mv;

   function automatic logic collide(input logic [9:0] x, input logic [8:0] y);
      logic [10:0] sx, sy;
      sx = {1'b0, x};
      sy = {2'b00, y};
      return (sx + SHOT_W11 > {1'b0, bossLocX_i})
          && (sx < {1'b0, bossLocX_i} + {1'b0, bossWidth_i})
          && (sy + SHOT_H11 > {2'b00, bossLocY_i})
          && (sy < {2'b00, bossLocY_i} + {2'b00, bossHeight_i});
   endfunction

`ifdef PLAYER_SHOT_AUTOFIRE_EN
   assign req = fire_i;
`else
   assign req = fire_i & ~prev_fire_q;
`endif

   always_comb begin
      slot_d     = slot_q;
      x_d        = x_q;
      y_d        = y_q;
      cooldown_d = cooldown_q;
      pending_d  = pending_q | req;
      hit_d      = 1'b0;
      placed     = 1'b0;
      y_mv       = '0;
      if (pulse_cycleStep_i) begin
         pending_d = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (slot_q[i] == SLOT_ACTIVE) begin
               if (y_q[i] < SPEED9) begin
                  slot_d[i] = SLOT_IDLE;
               end else begin
                  y_mv   = y_q[i] - SPEED9;
                  y_d[i] = y_mv;
                  if (collide(x_q[i], y_mv)) begin
                     slot_d[i] = SLOT_IDLE;
                     hit_d     = 1'b1;
                  end
               end
            end
         end
         // Only slots idle at tick start are candidates; slots freed above wait a tick.
         if ((pending_q | req) && cooldown_q == '0 && playerY_i >= SHOT_H9) begin
            for (int i = 0; i < 4; i++) begin
               if (!placed && slot_q[i] == SLOT_IDLE) begin
                  slot_d[i] = SLOT_ACTIVE;
                  x_d[i]    = playerX_i;
                  y_d[i]    = playerY_i - SHOT_H9;
                  placed    = 1'b1;
               end
            end
         end
         if (placed)
            cooldown_d = CD_LOAD;
         else if (cooldown_q != '0)
            cooldown_d = cooldown_q - 1'b1;
      end
   end

   always_ff @(posedge clk_master_i) begin
      if (rst_i) begin
         for (int i = 0; i < 4; i++) begin
            slot_q[i] <= SLOT_IDLE;
            x_q[i]    <= '0;
            y_q[i]    <= '0;
         end
         cooldown_q  <= '0;
         pending_q   <= 1'b0;
         prev_fire_q <= 1'b0;
         hit_q       <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         x_q         <= x_d;
         y_q         <= y_d;
         cooldown_q  <= cooldown_d;
         pending_q   <= pending_d;
         prev_fire_q <= fire_i;
         hit_q       <= hit_d;
      end
   end

   assign shot1X_o = x_q[0];
   assign shot2X_o = x_q[1];
   assign shot3X_o = x_q[2];
   assign shot4X_o = x_q[3];
   assign shot1Y_o = y_q[0];
   assign shot2Y_o = y_q[1];
   assign shot3Y_o = y_q[2];
   assign shot4Y_o = y_q[3];
   assign shotActive_o = {slot_q[3] == SLOT_ACTIVE, slot_q[2] == SLOT_ACTIVE,
                          slot_q[1] == SLOT_ACTIVE, slot_q[0] == SLOT_ACTIVE};
   assign bossHit_o = hit_q;

endmodule

// File: tb/tb_player_shot_controller.sv
// Directed bench for player_shot_controller: spawn, motion, top-edge exit, boss collision, cooldown and reset.
module tb_player_shot_controller;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       step = 1'b0;
   logic       fire = 1'b0;
   logic [9:0] player_x = 10'd300;
   logic [8:0] player_y = 9'd400;
   logic [9:0] boss_x = 10'd280;
   logic [8:0] boss_y = 9'd100;
   logic [9:0] boss_w = 10'd0;
   logic [8:0] boss_h = 9'd60;
   logic [9:0] s1x, s2x, s3x, s4x;
   logic [8:0] s1y, s2y, s3y, s4y;
   logic [3:0] active;
   logic       boss_hit;

   int total = 0;
   int bad = 0;
   logic hit1, hit2;
   int hit_count;
   int max_y;

   player_shot_controller dut (
      .clk_master_i(clk), .rst_i(rst), .pulse_cycleStep_i(step), .fire_i(fire),
      .playerX_i(player_x), .playerY_i(player_y),
      .bossLocX_i(boss_x), .bossLocY_i(boss_y), .bossWidth_i(boss_w), .bossHeight_i(boss_h),
      .shot1X_o(s1x), .shot2X_o(s2x), .shot3X_o(s3x), .shot4X_o(s4x),
      .shot1Y_o(s1y), .shot2Y_o(s2y), .shot3Y_o(s3y), .shot4Y_o(s4y),
      .shotActive_o(active), .bossHit_o(boss_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One tick every four clocks; hit1 is the cycle after the tick edge, hit2 the one after.
   task automatic do_tick();
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      hit1 = boss_hit;
      @(negedge clk) hit2 = boss_hit;
      @(negedge clk);
      if (hit1 | hit2) hit_count++;
   endtask

   task automatic fire_pulse();
      @(negedge clk) fire = 1'b1;
      @(negedge clk) fire = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      @(negedge clk) rst = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_act;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Spawn and motion
      fire_pulse();
      do_tick();
      chk("spawn_x", s1x, 300);
      chk("spawn_y", s1y, 392);
      chk("spawn_act", active, 4'b0001);
      do_tick();
      chk("move_y1", s1y, 388);
      do_tick();
      chk("move_y2", s1y, 384);

      // Reset with a live shot
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_act", active, 0);
      chk("rst_coords", {s1x, s2x, s3x, s4x, s1y, s2y, s3y, s4y} == '0, 1);
      chk("rst_hit", boss_hit, 0);
      rst = 1'b0;

      // Boss collision at the first post-move Y below 160
      boss_w = 10'd80;
      hit_count = 0;
      fire_pulse();
      do_tick();
      for (int k = 0; k < 58; k++) do_tick();
      chk("pre_hit_none", hit_count, 0);
      chk("pre_hit_y", s1y, 160);
      chk("pre_hit_act", active, 4'b0001);
      do_tick();
      chk("hit_pulse", hit1, 1);
      chk("hit_one_cycle", hit2, 0);
      chk("hit_cleared", active, 0);
      fire_pulse();
      do_tick();
      chk("reuse_act", active, 4'b0001);
      chk("reuse_y", s1y, 392);

      // Top-edge exit with no boss hit box
      boss_w = 10'd0;
      hit_count = 0;
      max_y = 0;
      for (int k = 0; k < 98; k++) begin
         do_tick();
         if (int'(s1y) > max_y) max_y = int'(s1y);
      end
      chk("top_y0", s1y, 0);
      chk("top_still_act", active, 4'b0001);
      do_tick();
      chk("top_cleared", active, 0);
      chk("top_no_wrap", s1y, 0);
      chk("top_no_hit", hit_count, 0);
      chk("top_max_y", max_y <= 392, 1);

      // Cooldown: fire edge before every tick
      do_reset();
      for (int t = 0; t < 25; t++) begin
         fire_pulse();
         do_tick();
         exp_act = (t >= 18) ? 4'b1111 : (t >= 12) ? 4'b0111 : (t >= 6) ? 4'b0011 : 4'b0001;
         chk($sformatf("cooldown_t%0d", t), active, exp_act);
         if (t == 6) begin
            chk("cd_s1y", s1y, 368);
            chk("cd_s2y", s2y, 392);
         end
      end
      do_reset();
      player_y = 9'd5;
      fire_pulse();
      do_tick();
      chk("low_player_no_spawn", active, 0);

      // Two shots hit in the same tick
      do_reset();
      boss_w = 10'd80;
      player_y = 9'd400;
      hit_count = 0;
      fire_pulse();
      do_tick();
      repeat (5) do_tick();
      player_y = 9'd376;
      fire_pulse();
      do_tick();
      chk("dual_act", active, 4'b0011);
      chk("dual_y_eq", {s1y, s2y}, {9'd368, 9'd368});
      for (int k = 0; k < 52; k++) do_tick();
      chk("dual_pre_none", hit_count, 0);
      do_tick();
      chk("dual_hit", hit1, 1);
      chk("dual_hit_once", hit2, 0);
      chk("dual_cleared", active, 0);
      chk("dual_pulses", hit_count, 1);

      // Fire held for 13 ticks
      do_reset();
      boss_w = 10'd0;
      player_y = 9'd400;
      @(negedge clk) fire = 1'b1;
      repeat (13) do_tick();
      fire = 1'b0;
`ifdef PLAYER_SHOT_AUTOFIRE_EN
      chk("held_fire_spawns", $countones(active), 3);
`else
      chk("held_fire_spawns", $countones(active), 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
